// File: rtl/xbus_bridge_arbiter.sv
// Round-robin arbiter that shares one xbus bridge slave port among NUM_MASTERS requesters,
// with a per-grant watchdog and an enforced idle gap between grants.
module xbus_bridge_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned GAP         = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_MASTERS-1:0]     m_cyc_i,
    input  logic [NUM_MASTERS-1:0]     m_stb_i,
    input  logic [NUM_MASTERS-1:0]     m_we_i,
    input  logic [16*NUM_MASTERS-1:0]  m_sel_i,
    input  logic [32*NUM_MASTERS-1:0]  m_adr_i,
    input  logic [128*NUM_MASTERS-1:0] m_dat_i,
    output logic [NUM_MASTERS-1:0]     m_ack_o,
    output logic [NUM_MASTERS-1:0]     m_berr_o,
    output logic [127:0]               m_dat_o,
    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    output logic                       s_we_o,
    output logic [15:0]                s_sel_o,
    output logic [31:0]                s_adr_o,
    output logic [127:0]               s_dat_o,
    input  logic                       s_ack_i,
    input  logic                       s_berr_i,
    input  logic [127:0]               s_dat_i,
    output logic [NUM_MASTERS-1:0]     gnt_o,
    output logic                       timeout_o
);

    localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT) + 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_ABORT,
        ST_GAP
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [WW-1:0]          wd_q, wd_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic                   s_cyc_q, s_cyc_d;
    logic                   s_stb_q, s_stb_d;
    logic                   s_we_q, s_we_d;
    logic [15:0]            s_sel_q, s_sel_d;
    logic [31:0]            s_adr_q, s_adr_d;
    logic [127:0]           s_dat_q, s_dat_d;
    logic                   timeout_q, timeout_d;

    logic [NUM_MASTERS-1:0] req;
    logic                   win_found;
    logic [IW-1:0]          win_idx;
    logic [IW-1:0]          cand_idx;
    logic [IW-1:0]          src_idx;

    logic [15:0]  sel_arr [NUM_MASTERS];
    logic [31:0]  adr_arr [NUM_MASTERS];
    logic [127:0] dat_arr [NUM_MASTERS];

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_slice
        assign sel_arr[k] = m_sel_i[16*k +: 16];
        assign adr_arr[k] = m_adr_i[32*k +: 32];
        assign dat_arr[k] = m_dat_i[128*k +: 128];
    end

    assign req = m_cyc_i & m_stb_i;

    // First requester at or after ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand_idx = IW'((32'(ptr_q) + i) % NUM_MASTERS);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign src_idx = (state_q == ST_IDLE) ? win_idx : gidx_q;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        gap_d     = gap_q;
        s_cyc_d   = s_cyc_q;
        s_stb_d   = s_stb_q;
        s_we_d    = s_we_q;
        s_sel_d   = s_sel_q;
        s_adr_d   = s_adr_q;
        s_dat_d   = s_dat_q;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    gnt_d   = NUM_MASTERS'(1) << win_idx;
                    gidx_d  = win_idx;
                    s_cyc_d = 1'b1;
                    s_stb_d = 1'b1;
                    s_we_d  = m_we_i[src_idx];
                    s_sel_d = sel_arr[src_idx];
                    s_adr_d = adr_arr[src_idx];
                    s_dat_d = dat_arr[src_idx];
                    wd_d    = '0;
                    if (32'(win_idx) == NUM_MASTERS - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_idx + 1'b1;
                    end
                    state_d = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                if (!m_cyc_i[gidx_q]) begin
                    s_cyc_d = 1'b0;
                    s_stb_d = 1'b0;
                    gnt_d   = '0;
                    gap_d   = '0;
                    state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    s_stb_d = m_stb_i[src_idx];
                    s_we_d  = m_we_i[src_idx];
                    s_sel_d = sel_arr[src_idx];
                    s_adr_d = adr_arr[src_idx];
                    s_dat_d = dat_arr[src_idx];
                    // A response in the expiry cycle takes priority over the abort.
                    if (s_ack_i || s_berr_i) begin
                        wd_d = '0;
                    end else if (wd_q >= WW'(TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        s_cyc_d   = 1'b0;
                        s_stb_d   = 1'b0;
                        state_d   = ST_ABORT;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end

            ST_ABORT: begin
                if (!m_cyc_i[gidx_q]) begin
                    gnt_d   = '0;
                    gap_d   = '0;
                    state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_q == GW'(GAP - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            wd_q      <= '0;
            gap_q     <= '0;
            s_cyc_q   <= 1'b0;
            s_stb_q   <= 1'b0;
            s_we_q    <= 1'b0;
            s_sel_q   <= '0;
            s_adr_q   <= '0;
            s_dat_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            wd_q      <= wd_d;
            gap_q     <= gap_d;
            s_cyc_q   <= s_cyc_d;
            s_stb_q   <= s_stb_d;
            s_we_q    <= s_we_d;
            s_sel_q   <= s_sel_d;
            s_adr_q   <= s_adr_d;
            s_dat_q   <= s_dat_d;
            timeout_q <= timeout_d;
        end
    end

    // Bridge responses reach only the granted master, with no added latency.
    always_comb begin
        m_ack_o  = '0;
        m_berr_o = '0;
        if (state_q == ST_ACTIVE) begin
            if (s_ack_i) m_ack_o = gnt_q;
            if (s_berr_i) m_berr_o = gnt_q;
        end else if (state_q == ST_ABORT && m_cyc_i[gidx_q]) begin
            m_berr_o = gnt_q;
        end
    end

    assign m_dat_o   = s_dat_i;
    assign s_cyc_o   = s_cyc_q;
    assign s_stb_o   = s_stb_q;
    assign s_we_o    = s_we_q;
    assign s_sel_o   = s_sel_q;
    assign s_adr_o   = s_adr_q;
    assign s_dat_o   = s_dat_q;
    assign gnt_o     = gnt_q;
    assign timeout_o = timeout_q;

endmodule
